// File: rtl/fa_check_pkg.sv
// Shared definitions for the full-adder response checker: FSM states, vector
// geometry and the golden full-adder function.
package fa_check_pkg;

  localparam int VEC_W    = 3;
  localparam int NUM_VECS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns {co_exp, s_exp} for vector index {a, b, ci}.
  function automatic logic [1:0] fa_golden(input logic [VEC_W-1:0] v);
    logic [1:0] r;
    r[0] = ^v;
    r[1] = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return r;
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Combinational golden full adder, reusable by any checker that needs reference s/co.
// Zero latency; no flow control.
module fa_ref_model
  import fa_check_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s_exp,
  output logic co_exp
);

  assign {co_exp, s_exp} = fa_golden({a, b, ci});

endmodule

// File: rtl/fa_response_checker.sv
// Judges observed full-adder outputs against the golden model, counting errors and coverage.
// Results are registered one edge after each sample; every valid sample in RUN is accepted (no backpressure).
module fa_response_checker
  import fa_check_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic                in_a,
  input  logic                in_b,
  input  logic                in_ci,
  input  logic                in_s,
  input  logic                in_co,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    sample_count,
  output logic [NUM_VECS-1:0] seen_mask,
  output logic                first_fail_valid,
  output logic [VEC_W-1:0]    first_fail_vec
);

  localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e              r_state;
  logic [CNT_W-1:0]    r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_VECS-1:0] r_mask;
  logic                r_ffv;
  logic [VEC_W-1:0]    r_ffvec;
  logic                r_timeout;
  logic [IDLE_W-1:0]   r_idle;

  logic [VEC_W-1:0]    w_v;
  logic                w_s_exp;
  logic                w_co_exp;
  logic                w_mismatch;
  logic                w_accept;
  logic [NUM_VECS-1:0] w_mask_next;

  assign w_v = {in_a, in_b, in_ci};

  fa_ref_model u_ref (
    .a      (in_a),
    .b      (in_b),
    .ci     (in_ci),
    .s_exp  (w_s_exp),
    .co_exp (w_co_exp)
  );

  assign w_mismatch  = (in_s != w_s_exp) || (in_co != w_co_exp);
  assign w_accept    = (r_state == ST_RUN) && in_valid;
  assign w_mask_next = r_mask | (w_accept ? (NUM_VECS'(1) << w_v) : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_err     <= '0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_ffv     <= 1'b0;
      r_ffvec   <= '0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end else if (r_state == ST_RUN) begin
      r_mask <= w_mask_next;
      if (w_accept) begin
        r_idle <= '0;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        if (w_mismatch) begin
          if (r_err != CNT_MAX) r_err <= r_err + CNT_W'(1);
          if (!r_ffv) begin
            r_ffv   <= 1'b1;
            r_ffvec <= w_v;
          end
        end
      end else begin
        r_idle <= r_idle + IDLE_W'(1);
      end
      // Coverage completion wins over timeout when both could fire.
      if (&w_mask_next) begin
        r_state <= ST_DONE;
      end else if (!w_accept && (r_idle == IDLE_LAST)) begin
        r_state   <= ST_DONE;
        r_timeout <= 1'b1;
      end
    end else if (start) begin
      r_state   <= ST_RUN;
      r_err     <= '0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_ffv     <= 1'b0;
      r_ffvec   <= '0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end
  end

  assign busy             = (r_state == ST_RUN);
  assign done             = (r_state == ST_DONE);
  assign pass             = done && (r_err == '0) && !r_timeout;
  assign timeout          = r_timeout;
  assign err_count        = r_err;
  assign sample_count     = r_cnt;
  assign seen_mask        = r_mask;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: vector table for full sweeps plus
// hand-written timeout, saturation, reset and ignored-input sequences.
module tb_fa_response_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_a = 1'b0, in_b = 1'b0, in_ci = 1'b0, in_s = 1'b0, in_co = 1'b0;
  logic       busy, done, pass, timeout, first_fail_valid;
  logic [3:0] err_count, sample_count;
  logic [7:0] seen_mask;
  logic [2:0] first_fail_vec;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fa_response_checker #(.CNT_W(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_s(in_s), .in_co(in_co),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .sample_count(sample_count), .seen_mask(seen_mask),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
  );

  typedef struct {
    logic       st;
    logic       vld;
    logic [2:0] v;
    logic       stuck;
    int         e_cnt;
    int         e_err;
    logic [7:0] e_mask;
    logic       e_busy;
    logic       e_done;
    logic       e_pass;
    logic       e_ffv;
    logic [2:0] e_ffvec;
  } row_t;

  row_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; outputs are observed 1 time unit after the edge.
  task automatic apply(input logic st, input logic vld, input logic [2:0] v, input logic stuck);
    start    = st;
    in_valid = vld;
    {in_a, in_b, in_ci} = v;
    in_s  = v[2] ^ v[1] ^ v[0];
    in_co = stuck ? 1'b0 : ((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
    @(posedge clock);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_cnt"}, sample_count, 0);
    chk({tag, "_mask"}, seen_mask, 0);
    chk({tag, "_ffv"}, first_fail_valid, 0);
    chk({tag, "_ffvec"}, first_fail_vec, 0);
  endtask

  initial begin
    int n;

    // Correct adder sweep; the sample in the start cycle is ignored.
    tbl.push_back('{1, 1, 3'd7, 0, 0, 0, 8'h00, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd0, 0, 1, 0, 8'h01, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd1, 0, 2, 0, 8'h03, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd2, 0, 3, 0, 8'h07, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd3, 0, 4, 0, 8'h0F, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd4, 0, 5, 0, 8'h1F, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd5, 0, 6, 0, 8'h3F, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd6, 0, 7, 0, 8'h7F, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd7, 0, 8, 0, 8'hFF, 0, 1, 1, 0, 3'd0});
    // Mismatching sample in DONE must be ignored.
    tbl.push_back('{0, 1, 3'd3, 1, 8, 0, 8'hFF, 0, 1, 1, 0, 3'd0});
    // Restart from DONE, then sweep with co stuck at 0: errors at 3, 5, 6, 7.
    tbl.push_back('{1, 0, 3'd0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd0, 1, 1, 0, 8'h01, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd1, 1, 2, 0, 8'h03, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd2, 1, 3, 0, 8'h07, 1, 0, 0, 0, 3'd0});
    tbl.push_back('{0, 1, 3'd3, 1, 4, 1, 8'h0F, 1, 0, 0, 1, 3'd3});
    tbl.push_back('{0, 1, 3'd4, 1, 5, 1, 8'h1F, 1, 0, 0, 1, 3'd3});
    tbl.push_back('{0, 1, 3'd5, 1, 6, 2, 8'h3F, 1, 0, 0, 1, 3'd3});
    tbl.push_back('{0, 1, 3'd6, 1, 7, 3, 8'h7F, 1, 0, 0, 1, 3'd3});
    tbl.push_back('{0, 1, 3'd7, 1, 8, 4, 8'hFF, 0, 1, 0, 1, 3'd3});

    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].st, tbl[i].vld, tbl[i].v, tbl[i].stuck);
      chk($sformatf("row%0d_cnt", i), sample_count, tbl[i].e_cnt);
      chk($sformatf("row%0d_err", i), err_count, tbl[i].e_err);
      chk($sformatf("row%0d_mask", i), seen_mask, tbl[i].e_mask);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("row%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("row%0d_pass", i), pass, tbl[i].e_pass);
      chk($sformatf("row%0d_ffv", i), first_fail_valid, tbl[i].e_ffv);
      chk($sformatf("row%0d_ffvec", i), first_fail_vec, tbl[i].e_ffvec);
      chk($sformatf("row%0d_tmo", i), timeout, 0);
    end

    // Timeout after vectors 0..6: DONE 16 edges after the last sample.
    apply(1, 0, 3'd0, 0);
    for (int v = 0; v < 7; v++) apply(0, 1, 3'(v), 0);
    chk("to_busy_before", busy, 1);
    wait_done(n);
    chk("to_latency", n, 16);
    chk("to_timeout", timeout, 1);
    chk("to_mask", seen_mask, 8'h7F);
    chk("to_pass", pass, 0);
    chk("to_cnt", sample_count, 7);

    // Timeout with no samples at all: DONE 16 edges after entering RUN.
    apply(1, 0, 3'd0, 0);
    wait_done(n);
    chk("to0_latency", n, 16);
    chk("to0_cnt", sample_count, 0);
    chk("to0_timeout", timeout, 1);
    chk("to0_pass", pass, 0);

    // Saturation: vector 5 twenty times, then a full sweep.
    apply(1, 0, 3'd0, 0);
    chk("sat_tmo_clear", timeout, 0);
    repeat (20) apply(0, 1, 3'd5, 0);
    chk("sat_cnt", sample_count, 15);
    chk("sat_mask", seen_mask, 8'h20);
    chk("sat_busy", busy, 1);
    for (int v = 0; v < 8; v++) apply(0, 1, 3'(v), 0);
    chk("sat_cnt_end", sample_count, 15);
    chk("sat_done", done, 1);
    chk("sat_pass", pass, 1);
    chk("sat_mask_end", seen_mask, 8'hFF);

    // Reset mid-run, held together with start and a sample.
    apply(1, 0, 3'd0, 0);
    for (int v = 0; v < 3; v++) apply(0, 1, 3'(v), 1);
    chk("rst_pre_cnt", sample_count, 3);
    reset = 1'b1;
    apply(1, 1, 3'd3, 1);
    reset = 1'b0;
    chk_reset_vals("rst");
    // Sample in IDLE is ignored.
    apply(0, 1, 3'd7, 1);
    chk("idle_cnt", sample_count, 0);
    chk("idle_mask", seen_mask, 0);
    chk("idle_busy", busy, 0);
    // Full sweep with start asserted mid-run (must not restart).
    apply(1, 0, 3'd0, 0);
    for (int v = 0; v < 3; v++) apply(0, 1, 3'(v), 0);
    apply(1, 1, 3'd3, 0);
    chk("runstart_cnt", sample_count, 4);
    chk("runstart_mask", seen_mask, 8'h0F);
    chk("runstart_busy", busy, 1);
    for (int v = 4; v < 8; v++) apply(0, 1, 3'(v), 0);
    chk("post_done", done, 1);
    chk("post_pass", pass, 1);
    chk("post_cnt", sample_count, 8);
    chk("post_err", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fa_response_checker.md
# fa_response_checker

Response-side companion to the full-adder stimulus counter. It consumes the stream of applied inputs (a, b, ci) and the adder's observed outputs (s, co), computes the golden sum/carry, and counts mismatches. It tracks coverage of all 8 input combinations and reports a pass/fail verdict. It sits beside the adder in lab benches and on-board self-test: the stimulus counter writes vectors, and this block reads and judges them.

## Interface
Parameters:
- CNT_W, 4, width of mismatch and sample counters (both saturate at 2^CNT_W−1)
- TIMEOUT, 64, idle cycles in RUN without an accepted sample before forced completion (≥1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock domain; clears all state
- start  in  1  begin a check run (pulse)
- in_valid  in  1  sample qualifier
- in_a, in_b, in_ci  in  1 each  stimulus applied to the adder
- in_s, in_co  in  1 each  adder outputs under test
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  done && err_count==0 && !timeout
- timeout  out  1  run ended by TIMEOUT
- err_count  out  CNT_W  mismatching samples
- sample_count  out  CNT_W  accepted samples
- seen_mask  out  8  bit v set once vector v has been observed
- first_fail_valid  out  1  a mismatch has been recorded
- first_fail_vec  out  3  index of the first mismatching vector

## Operation
- Vector index v = {in_a, in_b, in_ci}; in_ci is the LSB, matching the stimulus counter order.
- Golden model: s_exp = a^b^ci; co_exp = ab | a·ci | b·ci. A mismatch is (in_s≠s_exp) or (in_co≠co_exp).
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start. All counters, the mask, the first-fail fields and timeout clear on this edge.
  - RUN: a sample is accepted when in_valid=1. On acceptance: sample_count++, seen_mask[v]←1, err_count++ if mismatch. On the first mismatch only, first_fail_vec←v and first_fail_valid←1. The idle counter reloads to 0 on every accepted sample and increments otherwise.
  - RUN → DONE when seen_mask becomes all-ones, including from the current sample. RUN → DONE with timeout←1 when the idle counter reaches TIMEOUT−1 and no sample is accepted that cycle.
  - DONE → RUN on start, which clears everything as from IDLE. Otherwise DONE holds all results.
- Ignored inputs:
  - start in RUN.
  - in_valid in IDLE and DONE, including a sample arriving in the same cycle as start.
- Repeated vectors are counted and checked normally; they do not advance coverage.
- Counters saturate and never wrap.

## Timing
- Reset values: state IDLE; busy=0, done=0, pass=0, timeout=0, err_count=0, sample_count=0, seen_mask=0, first_fail_valid=0, first_fail_vec=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A sample accepted at edge N is reflected in counters and the mask after edge N.
- done rises after the same edge that sets the last seen_mask bit. Latency is 0 extra cycles.
- busy rises the cycle after start is sampled.
- Reset asserted mid-run returns the block to its reset values at the next edge, regardless of state. Reset takes priority over start.
- Timeout with no samples: DONE is entered TIMEOUT cycles after entering RUN.

## Structure
- Package fa_check_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - VEC_W=3 and NUM_VECS=8
  - a function returning {co_exp, s_exp} from the vector index
- The sub-module fa_ref_model is the natural split: a combinational golden adder instantiated once, with inputs a, b, ci and outputs s_exp, co_exp. It is reusable by other checkers.
- The top contains the FSM, counters and mask registers.

## Test plan
- Correct adder, vectors 0..7 in order, one per cycle after start → done after the 8th edge; pass=1, err_count=0, sample_count=8, seen_mask=8'hFF.
- Adder with co stuck at 0 → err_count=4 (vectors 3, 5, 6, 7), first_fail_vec=3, first_fail_valid=1, pass=0.
- Only vectors 0..6 supplied, then in_valid low, TIMEOUT=16 → DONE 16 cycles after the last sample; timeout=1, seen_mask=8'h7F, pass=0.
- Vector 5 repeated 20 times, then all 8 vectors with CNT_W=4 → sample_count saturates at 15; done when the mask fills.
- Reset asserted after 3 samples in RUN → next cycle all outputs are at reset values. A subsequent start and full sweep gives pass=1.
- in_valid pulses in IDLE and in DONE, plus start during RUN → counters unchanged and no run restart; start in DONE clears results and restarts.
